// File: rtl/mem_port_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | core0_mem_pkg : shared types and constants for the unified-memory arbiter |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package core0_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } mem_owner_e;

  localparam int WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter_if : fetch, data and memory-side signals of the arbiter  |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  // Requesters and the memory model sit on the master side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_we
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter : data-over-fetch arbiter for a single-port word memory  |
// | Optional stall counters under MEM_ARB_PERF_EN.  Revision : 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import core0_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]        if_stall_cnt,
  output logic [31:0]        d_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] c_starve_lim = CNT_W'(STARVE_LIMIT);

  mem_owner_e       r_owner;
  mem_owner_e       w_owner_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [31:0]      r_if_rdata;
  logic [31:0]      r_d_rdata;
  logic [31:0]      r_last_addr;
  logic             w_force_if;
  logic             w_if_gnt;
  logic             w_d_gnt;

  // Gating with rst_n keeps the memory untouched while reset is held.
  assign w_force_if = bus.if_req && (r_starve_cnt >= c_starve_lim);
  assign w_d_gnt    = rst_n && bus.d_req && !w_force_if;
  assign w_if_gnt   = rst_n && bus.if_req && !w_d_gnt;

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = (r_owner == OWN_IF);
  assign bus.d_rvalid  = (r_owner == OWN_D_RD) || (r_owner == OWN_D_WR);
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;

  always_comb begin
    bus.mem_addr  = r_last_addr;
    bus.mem_wdata = 32'h0;
    bus.mem_we    = 1'b0;
    w_owner_nxt   = OWN_NONE;
    if (w_d_gnt) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_we    = bus.d_we;
      w_owner_nxt   = bus.d_we ? OWN_D_WR : OWN_D_RD;
    end else if (w_if_gnt) begin
      bus.mem_addr = bus.if_addr;
      w_owner_nxt  = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_if_rdata   <= 32'h0;
      r_d_rdata    <= 32'h0;
      r_last_addr  <= 32'h0;
    end else begin
      if (w_if_gnt || !bus.if_req) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt < c_starve_lim) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
      if (w_if_gnt) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (w_d_gnt && !bus.d_we) begin
        r_d_rdata <= bus.mem_rdata;
      end
      if (w_if_gnt || w_d_gnt) begin
        r_last_addr <= bus.mem_addr;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_stall_cnt <= 32'h0;
      d_stall_cnt  <= 32'h0;
    end else begin
      if (bus.if_req && !w_if_gnt) begin
        if_stall_cnt <= if_stall_cnt + 32'd1;
      end
      if (bus.d_req && !w_d_gnt) begin
        d_stall_cnt <= d_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed stimulus with queued expected responses    |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;
  import core0_mem_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   cyc;
  exp_t q_if[$];
  exp_t q_d[$];
  logic [31:0] mem [0:63];

  mem_port_arbiter_if bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_stall_cnt;
  logic [31:0] d_stall_cnt;
`endif

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef MEM_ARB_PERF_EN
    ,
    .if_stall_cnt (if_stall_cnt),
    .d_stall_cnt  (d_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word memory: combinational read, misaligned writes dropped.
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'hA5A50020;
    end else if (bus.mem_we && (bus.mem_addr % WORD_BYTES == 0)) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  // Response monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.if_rvalid) begin
      checks++;
      if (q_if.size() == 0) begin
        errors++;
        $display("FAIL if_rvalid_unexpected: got if_rvalid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q_if.pop_front();
        if (bus.if_rdata !== e.data || cyc != e.cyc + 1) begin
          errors++;
          $display("FAIL if_resp: got data=%h cycle=%0d, required data=%h cycle=%0d",
                   bus.if_rdata, cyc, e.data, e.cyc + 1);
        end
      end
    end
    if (bus.d_rvalid) begin
      checks++;
      if (q_d.size() == 0) begin
        errors++;
        $display("FAIL d_rvalid_unexpected: got d_rvalid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q_d.pop_front();
        if (bus.d_rdata !== e.data || cyc != e.cyc + 1) begin
          errors++;
          $display("FAIL d_resp: got data=%h cycle=%0d, required data=%h cycle=%0d",
                   bus.d_rdata, cyc, e.data, e.cyc + 1);
        end
      end
    end
  end

  task automatic check32(input logic [31:0] got, input logic [31:0] req, input string nm);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  task automatic drv(input logic ir, input logic [31:0] ia, input logic dr,
                     input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dd;
  endtask

  task automatic chk(input logic eig, input logic edg, input logic [31:0] idat,
                     input logic [31:0] ddat, input bit push, input string nm);
    @(negedge clk);
    check32({31'h0, bus.if_gnt}, {31'h0, eig}, {nm, "_if_gnt"});
    check32({31'h0, bus.d_gnt},  {31'h0, edg}, {nm, "_d_gnt"});
    if (push && eig) q_if.push_back('{data: idat, cyc: cyc});
    if (push && edg) q_d.push_back('{data: ddat, cyc: cyc});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h8;
    bus.d_wdata = 32'hFFFF_FFFF;

    // Requests held during reset must not reach the memory.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32({29'h0, bus.if_gnt, bus.d_gnt, bus.mem_we}, 32'h0, "reset_gnt_we");
    check32({30'h0, bus.if_rvalid, bus.d_rvalid}, 32'h0, "reset_rvalid");
`ifdef MEM_ARB_PERF_EN
    check32(if_stall_cnt | d_stall_cnt, 32'h0, "reset_perf");
`endif

    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_wdata = 32'h0;
    repeat (5) begin
      @(negedge clk);
      check32({30'h0, bus.if_rvalid, bus.d_rvalid} | bus.if_rdata | bus.d_rdata |
              bus.mem_addr | {31'h0, bus.mem_we} | {30'h0, bus.if_gnt, bus.d_gnt},
              32'h0, "idle_after_reset");
    end

    // Three-cycle collision: data wins every cycle, fetch stalls three times.
    drv(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    repeat (3) chk(1'b0, 1'b1, 32'h0, 32'hA5A50020, 1'b1, "coll3");
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "idle0");
`ifdef MEM_ARB_PERF_EN
    check32(if_stall_cnt, 32'd3, "perf_if_stall");
    check32(d_stall_cnt,  32'd0, "perf_d_stall");
`endif

    // Fetch alone; then the idle address holds the last grant.
    drv(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    chk(1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1, "if_rd");
    check32(bus.mem_addr, 32'h10, "if_rd_addr");
    check32(bus.mem_wdata | {31'h0, bus.mem_we}, 32'h0, "if_rd_nowrite");
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "idle1");
    check32(bus.mem_addr, 32'h10, "idle_addr_hold");

    // Six-cycle collision: fetch is forced through after four denials.
    drv(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 6; i++)
      chk(i == 4, i != 4, 32'hDEADBEEF, 32'hA5A50020, 1'b1, "coll6");
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "idle2");

    // Write is only acked; d_rdata keeps the last load value.
    drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h12345678);
    chk(1'b0, 1'b1, 32'h0, 32'hA5A50020, 1'b1, "d_wr");
    check32({31'h0, bus.mem_we}, 32'h1, "d_wr_we");
    check32(bus.mem_addr, 32'h8, "d_wr_addr");
    check32(bus.mem_wdata, 32'h12345678, "d_wr_wdata");
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "idle3");
    check32({31'h0, bus.mem_we}, 32'h0, "idle3_we");
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
    chk(1'b0, 1'b1, 32'h0, 32'h12345678, 1'b1, "d_rd");

    // Misaligned write is forwarded and acked, memory ignores it.
    drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h9, 32'hFFFF_FFFF);
    chk(1'b0, 1'b1, 32'h0, 32'h12345678, 1'b1, "d_wr_mis");
    check32(bus.mem_addr, 32'h9, "d_wr_mis_addr");
    drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
    chk(1'b0, 1'b1, 32'h0, 32'h12345678, 1'b1, "d_rd2");
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "idle4");

    // Async reset while a fetch response is on the bus.
    drv(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    chk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "if_rd_rst");
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check32({31'h0, bus.if_rvalid}, 32'h1, "pre_rst_rvalid");
    check32(bus.if_rdata, 32'hDEADBEEF, "pre_rst_rdata");
    #1;
    rst_n = 1'b0;
    #1;
    check32({31'h0, bus.if_rvalid}, 32'h0, "async_rst_rvalid");
    check32(bus.if_rdata, 32'h0, "async_rst_rdata");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) chk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "post_rst");

    @(negedge clk);
    check32(32'(q_if.size() + q_d.size()), 32'h0, "missing_responses");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
